mux_4_arbiter: RTL and testbench

MUX_4_ARBITER -- requirements
Module: Mux_4_Arbiter

---
 rtl/mux_4_arbiter.sv | 109 ++++++++++
 tb/tb_mux_4_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mux_4_arbiter.sv
// mux_4_arbiter
//   Four-source packet arbiter with a registered output stage.
//   A source that wins arbitration keeps the output until it sends a beat
//   with i_Last set. Between packets, sources are served round-robin,
//   starting after the last source that finished a packet.
//
// Ports
//   i_Clk, i_Rst          clock, synchronous active-high reset
//   i_Valid[3:0]          per-source valid (bit k = source k)
//   i_Last[3:0]           per-source end-of-packet, qualified by i_Valid
//   i_Data1..i_Data4      source data for sources 0..3
//   o_Ready[3:0]          combinational accept strobe, one-hot or zero
//   o_Valid/o_Data/o_Last registered output beat
//   o_Select[1:0]         registered index of the source that produced o_Data
//   i_Ready               downstream accept
module mux_4_arbiter #(
    parameter int g_WIDTH = 8
) (
    input  logic               i_Clk,
    input  logic               i_Rst,
    input  logic [3:0]         i_Valid,
    input  logic [3:0]         i_Last,
    input  logic [g_WIDTH-1:0] i_Data1,
    input  logic [g_WIDTH-1:0] i_Data2,
    input  logic [g_WIDTH-1:0] i_Data3,
    input  logic [g_WIDTH-1:0] i_Data4,
    output logic [3:0]         o_Ready,
    output logic               o_Valid,
    output logic [g_WIDTH-1:0] o_Data,
    output logic               o_Last,
    output logic [1:0]         o_Select,
    input  logic               i_Ready
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t             state;
    logic [1:0]         ptr;     // last source to finish a packet
    logic [1:0]         owner;   // source holding the lock in LOCKED
    logic               load;
    logic               found;
    logic               accept;
    logic [1:0]         grant;
    logic [1:0]         idx;
    logic [g_WIDTH-1:0] src_data [4];

    assign src_data[0] = i_Data1;
    assign src_data[1] = i_Data2;
    assign src_data[2] = i_Data3;
    assign src_data[3] = i_Data4;

    // The output register can take a new beat when empty or draining.
    assign load = !o_Valid || i_Ready;

    // Grant selection uses only control inputs; data never reaches o_Ready.
    always_comb begin
        grant = owner;
        found = 1'b0;
        idx   = 2'd0;
        if (state == IDLE) begin
            // Search ptr+1, ptr+2, ptr+3, ptr; the 2-bit add wraps mod 4.
            for (int k = 1; k <= 4; k++) begin
                idx = ptr + 2'(k);
                if (!found && i_Valid[idx]) begin
                    grant = idx;
                    found = 1'b1;
                end
            end
        end else begin
            // Locked: only the owner may move, a gap in its valid keeps the lock.
            found = i_Valid[owner];
        end
    end

    assign accept  = !i_Rst && load && found;
    assign o_Ready = accept ? (4'b0001 << grant) : 4'b0000;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state    <= IDLE;
            ptr      <= 2'd3;
            owner    <= 2'd0;
            o_Valid  <= 1'b0;
            o_Data   <= '0;
            o_Last   <= 1'b0;
            o_Select <= 2'd0;
        end else if (accept) begin
            o_Valid  <= 1'b1;
            o_Data   <= src_data[grant];
            o_Last   <= i_Last[grant];
            o_Select <= grant;
            if (state == IDLE) begin
                if (i_Last[grant]) begin
                    ptr <= grant;           // single-beat packet, never locks
                end else begin
                    state <= LOCKED;
                    owner <= grant;
                end
            end else if (i_Last[grant]) begin
                ptr   <= grant;
                state <= IDLE;
            end
        end else if (load) begin
            // Register drained with nothing new: drop valid, hold payload.
            o_Valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_4_arbiter.sv
module tb_mux_4_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] valid = 4'b0;
    logic [3:0] last = 4'b0;
    logic       rdy = 1'b1;
    logic [7:0] d [4];
    logic [3:0] o_ready;
    logic       o_valid;
    logic [7:0] o_data;
    logic       o_last;
    logic [1:0] o_sel;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    mux_4_arbiter #(.g_WIDTH(8)) dut (
        .i_Clk(clk), .i_Rst(rst), .i_Valid(valid), .i_Last(last),
        .i_Data1(d[0]), .i_Data2(d[1]), .i_Data3(d[2]), .i_Data4(d[3]),
        .o_Ready(o_ready), .o_Valid(o_valid), .o_Data(o_data),
        .o_Last(o_last), .o_Select(o_sel), .i_Ready(rdy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit       m_locked;
    int       m_owner;
    int       m_ptr;
    bit       m_valid;
    bit [7:0] m_data;
    bit       m_last;
    int       m_sel;

    // Which source (0..3) the rules allow to transfer this cycle, or -1.
    function automatic int pick();
        if (rst) return -1;
        if (m_valid && !rdy) return -1;
        if (m_locked) return valid[m_owner] ? m_owner : -1;
        for (int k = 1; k <= 4; k++)
            if (valid[(m_ptr + k) % 4]) return (m_ptr + k) % 4;
        return -1;
    endfunction

    function automatic logic [3:0] exp_ready();
        int s;
        s = pick();
        return (s < 0) ? 4'b0000 : 4'(1 << s);
    endfunction

    always @(posedge clk) begin
        int s;
        s = pick();
        if (rst) begin
            m_locked <= 1'b0; m_owner <= 0; m_ptr <= 3;
            m_valid <= 1'b0; m_data <= 8'h00; m_last <= 1'b0; m_sel <= 0;
        end else if (s >= 0) begin
            m_valid <= 1'b1;
            m_data  <= d[s];
            m_last  <= last[s];
            m_sel   <= s;
            if (last[s]) begin
                m_ptr <= s;
                m_locked <= 1'b0;
            end else begin
                m_locked <= 1'b1;
                m_owner  <= s;
            end
        end else if (!m_valid || rdy) begin
            m_valid <= 1'b0;
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(o_ready), 32'(exp_ready()));
            chk("o_valid", 32'(o_valid), 32'(m_valid));
            chk("o_data", 32'(o_data), 32'(m_data));
            chk("o_last", 32'(o_last), 32'(m_last));
            chk("o_select", 32'(o_sel), 32'(m_sel));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 4; i++) d[i] = 8'(8'h10 * (i + 1) + i);

        // Reset, then check reset state literally.
        rst = 1'b1;
        tick();
        chk_en = 1'b1;
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_data", 32'(o_data), 0);
        chk("rst_select", 32'(o_sel), 0);
        chk("rst_ready", 32'(o_ready), 0);

        // Round robin with every source sending single beats.
        rst = 1'b0; valid = 4'b1111; last = 4'b1111; rdy = 1'b1;
        #1 chk("first_grant", 32'(o_ready), 32'h1);
        for (int i = 0; i < 8; i++) begin
            tick();
            chk("rr_select", 32'(o_sel), 32'(i % 4));
            chk("rr_valid", 32'(o_valid), 1);
        end

        // Source 2 sends a 3-beat packet while source 0 waits.
        valid = 4'b0100; last = 4'b0000;
        tick(); chk("pkt_b1", 32'(o_sel), 2);
        valid = 4'b0101; last = 4'b0001;
        #1 chk("pkt_block0", 32'(o_ready), 32'h4);
        tick(); chk("pkt_b2", 32'(o_sel), 2);
        last = 4'b0101;
        tick(); chk("pkt_b3", 32'(o_sel), 2);
        chk("pkt_b3_last", 32'(o_last), 1);
        tick(); chk("pkt_then0", 32'(o_sel), 0);

        // Stall with 8'hA5 held in the output register.
        valid = 4'b0000;
        tick(); chk("drain", 32'(o_valid), 0);
        d[1] = 8'hA5; valid = 4'b0010; last = 4'b0010;
        tick(); chk("a5_data", 32'(o_data), 32'hA5);
        rdy = 1'b0; valid = 4'b0101; d[1] = 8'h3C;
        for (int i = 0; i < 5; i++) begin
            #1 chk("stall_ready", 32'(o_ready), 0);
            tick();
            chk("stall_data", 32'(o_data), 32'hA5);
            chk("stall_valid", 32'(o_valid), 1);
        end
        rdy = 1'b1;

        // Lock on source 1, then source 1 goes quiet while source 3 asks.
        valid = 4'b0010; last = 4'b0000;
        tick(); chk("lock1", 32'(o_sel), 1);
        valid = 4'b1000; last = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            #1 chk("gap_ready", 32'(o_ready), 0);
            tick();
            chk("gap_valid", 32'(o_valid), 0);
        end
        valid = 4'b1010; last = 4'b1010;
        #1 chk("gap_resume", 32'(o_ready), 32'h2);
        tick(); chk("gap_sel", 32'(o_sel), 1);

        // Reset in the middle of a source 3 packet.
        valid = 4'b1000; last = 4'b0000;
        tick(); chk("lock3_b1", 32'(o_sel), 3);
        tick(); chk("lock3_b2", 32'(o_sel), 3);
        rst = 1'b1;
        #1 chk("rst_ready_mid", 32'(o_ready), 0);
        tick(); chk("rst_drop", 32'(o_valid), 0);
        rst = 1'b0; valid = 4'b1111; last = 4'b1111;
        #1 chk("post_rst_grant", 32'(o_ready), 32'h1);
        tick(); chk("post_rst_sel", 32'(o_sel), 0);

        // Single source streaming single-beat packets.
        valid = 4'b0010; last = 4'b0010;
        for (int i = 0; i < 6; i++) begin
            d[1] = 8'(8'h40 + i);
            #1 chk("solo_ready", 32'(o_ready), 32'h2);
            tick();
            chk("solo_data", 32'(o_data), 32'(8'h40 + i));
            chk("solo_valid", 32'(o_valid), 1);
        end

        // Randomized traffic checked by the compare process.
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 199) == 0);
            valid = 4'($urandom);
            last  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'($urandom & $urandom);
            rdy   = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 4; k++) d[k] = 8'($urandom);
            tick();
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
